// File: rtl/quad_enc_speed.sv
// Quadrature encoder interface: two-flop input synchroniser, x1/x4 Gray decode,
// windowed signed edge count (speed) with saturation, free-running position,
// direction of last step and a sticky illegal-transition flag.
module quad_enc_speed #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  parameter int POS_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enc_a,
  input  logic                    enc_b,
  input  logic                    en,
  input  logic                    mode_x4,
  input  logic [WIN_W-1:0]        win_len,
  input  logic                    err_clr,
  output logic signed [CNT_W-1:0] speed,
  output logic                    speed_valid,
  output logic                    speed_sat,
  output logic signed [POS_W-1:0] position,
  output logic                    dir,
  output logic                    err
);

  // Accumulator clamp limits and the minimum window length.
  localparam logic signed [CNT_W-1:0] ACC_MAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] ACC_MIN = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [WIN_W-1:0]        LEN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_W-1:0]        LEN_ZERO = {WIN_W{1'b0}};

  // AB patterns, channel A in bit 1. Forward order is 00 -> 10 -> 11 -> 01 -> 00.
  localparam logic [1:0] AB_00 = 2'b00;
  localparam logic [1:0] AB_10 = 2'b10;
  localparam logic [1:0] AB_11 = 2'b11;
  localparam logic [1:0] AB_01 = 2'b01;

  // True when prev -> cur is one forward step of the Gray sequence.
  function automatic logic is_fwd(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    logic res;
    case ({prev_ab, cur_ab})
      {AB_00, AB_10},
      {AB_10, AB_11},
      {AB_11, AB_01},
      {AB_01, AB_00}: res = 1'b1;
      default:        res = 1'b0;
    endcase
    return res;
  endfunction

  // Synchroniser and decode state
  logic                    r_a_meta;
  logic                    r_a_sync;
  logic                    r_b_meta;
  logic                    r_b_sync;
  logic [1:0]              r_prev;

  // Measurement state
  logic                    r_err;
  logic                    r_dir;
  logic signed [POS_W-1:0] r_position;
  logic [WIN_W-1:0]        r_wcnt;
  logic [WIN_W-1:0]        r_len;
  logic signed [CNT_W-1:0] r_accum;
  logic                    r_sat;
  logic signed [CNT_W-1:0] r_speed;
  logic                    r_speed_sat;
  logic                    r_speed_valid;

  // Combinational decode / datapath
  logic [1:0]              w_cur;
  logic [1:0]              w_chg;
  logic                    w_fwd;
  logic                    w_rev;
  logic                    w_illegal;
  logic signed [1:0]       w_step;
  logic signed [CNT_W:0]   w_sum;
  logic signed [CNT_W-1:0] w_acc_next;
  logic                    w_clamp;
  logic [WIN_W-1:0]        w_len_start;
  logic [WIN_W-1:0]        w_len_cur;
  logic [WIN_W-1:0]        w_len_last;
  logic                    w_win_last;

  assign w_cur = {r_a_sync, r_b_sync};
  assign w_chg = w_cur ^ r_prev;

  // Two-flop synchroniser for the asynchronous encoder pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_meta <= 1'b0;
      r_a_sync <= 1'b0;
      r_b_meta <= 1'b0;
      r_b_sync <= 1'b0;
    end else begin
      r_a_meta <= enc_a;
      r_a_sync <= r_a_meta;
      r_b_meta <= enc_b;
      r_b_sync <= r_b_meta;
    end
  end

  // Previous synchronised AB; tracks even while disabled so re-enable is step-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 2'b00;
    end else begin
      r_prev <= w_cur;
    end
  end

  // Classify the prev -> cur transition as forward, reverse, illegal or none.
  always_comb begin
    w_fwd     = 1'b0;
    w_rev     = 1'b0;
    w_illegal = 1'b0;
    if (w_chg == 2'b11) begin
      w_illegal = 1'b1;
    end else if (w_chg == 2'b00) begin
      w_fwd = 1'b0;
    end else if (mode_x4) begin
      w_fwd = is_fwd(r_prev, w_cur);
      w_rev = !is_fwd(r_prev, w_cur);
    end else if (!r_prev[1] && w_cur[1]) begin
      // x1: only A rising counts; B level gives the direction.
      w_fwd = !w_cur[0];
      w_rev = w_cur[0];
    end else begin
      w_fwd = 1'b0;
    end
  end

  // Signed step value: +1, -1 or 0.
  always_comb begin
    w_step = 2'sb00;
    if (w_fwd) begin
      w_step = 2'sb01;
    end else if (w_rev) begin
      w_step = 2'sb11;
    end else begin
      w_step = 2'sb00;
    end
  end

  // Saturating add of the step into the window accumulator.
  always_comb begin
    w_sum      = {r_accum[CNT_W-1], r_accum} + {{(CNT_W-1){w_step[1]}}, w_step};
    w_acc_next = w_sum[CNT_W-1:0];
    w_clamp    = 1'b0;
    if (w_sum[CNT_W] != w_sum[CNT_W-1]) begin
      w_clamp    = 1'b1;
      w_acc_next = w_sum[CNT_W] ? ACC_MIN : ACC_MAX;
    end else begin
      w_clamp    = 1'b0;
    end
  end

  // Window length in force: sampled from win_len at window start, then held.
  always_comb begin
    w_len_start = win_len;
    w_len_cur   = r_len;
    if (win_len == LEN_ZERO) begin
      w_len_start = LEN_ONE;
    end else begin
      w_len_start = win_len;
    end
    if (r_wcnt == LEN_ZERO) begin
      w_len_cur = w_len_start;
    end else begin
      w_len_cur = r_len;
    end
    w_len_last = w_len_cur - LEN_ONE;
    w_win_last = (r_wcnt == w_len_last);
  end

  // Sticky illegal-transition flag; a new illegal event beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err;
    end
  end

  // Running position and direction of the last counted step, frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_position <= '0;
      r_dir      <= 1'b0;
    end else if (en && (w_fwd || w_rev)) begin
      r_position <= r_position + {{(POS_W-2){w_step[1]}}, w_step};
      r_dir      <= w_fwd;
    end else begin
      r_position <= r_position;
      r_dir      <= r_dir;
    end
  end

  // Gate window: counter, captured length, accumulator and clamp flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt  <= LEN_ZERO;
      r_len   <= LEN_ZERO;
      r_accum <= '0;
      r_sat   <= 1'b0;
    end else if (!en) begin
      r_wcnt  <= LEN_ZERO;
      r_len   <= r_len;
      r_accum <= '0;
      r_sat   <= 1'b0;
    end else begin
      if (r_wcnt == LEN_ZERO) begin
        r_len <= w_len_start;
      end else begin
        r_len <= r_len;
      end
      if (w_win_last) begin
        r_wcnt  <= LEN_ZERO;
        r_accum <= '0;
        r_sat   <= 1'b0;
      end else begin
        r_wcnt  <= r_wcnt + LEN_ONE;
        r_accum <= w_acc_next;
        r_sat   <= r_sat | w_clamp;
      end
    end
  end

  // Latch the closing window (including its terminal-cycle step) as a speed sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_speed       <= '0;
      r_speed_sat   <= 1'b0;
      r_speed_valid <= 1'b0;
    end else if (en && w_win_last) begin
      r_speed       <= w_acc_next;
      r_speed_sat   <= r_sat | w_clamp;
      r_speed_valid <= 1'b1;
    end else begin
      r_speed       <= r_speed;
      r_speed_sat   <= r_speed_sat;
      r_speed_valid <= 1'b0;
    end
  end

  assign speed       = r_speed;
  assign speed_valid = r_speed_valid;
  assign speed_sat   = r_speed_sat;
  assign position    = r_position;
  assign dir         = r_dir;
  assign err         = r_err;

endmodule

// File: tb/tb_quad_enc_speed.sv
// Bench for quad_enc_speed: table of directed scenarios, hand-written corner
// sequences and a randomized phase, all checked every cycle against a Gray-index
// reference model. A second instance with CNT_W=8 exercises saturation.
module tb_quad_enc_speed;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enc_a;
  logic        enc_b;
  logic        en;
  logic        mode_x4;
  logic [15:0] win_len;
  logic        err_clr;

  logic signed [15:0] speed;
  logic               speed_valid;
  logic               speed_sat;
  logic [31:0]        position;
  logic               dir;
  logic               err;

  logic signed [7:0]  speed8;
  logic               valid8;
  logic               sat8;
  logic [31:0]        pos8;
  logic               dir8;
  logic               err8;

  quad_enc_speed #(.CNT_W(16), .WIN_W(16), .POS_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
    .mode_x4(mode_x4), .win_len(win_len), .err_clr(err_clr),
    .speed(speed), .speed_valid(speed_valid), .speed_sat(speed_sat),
    .position(position), .dir(dir), .err(err)
  );

  quad_enc_speed #(.CNT_W(8), .WIN_W(16), .POS_W(32)) dut8 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .en(en),
    .mode_x4(mode_x4), .win_len(win_len), .err_clr(err_clr),
    .speed(speed8), .speed_valid(valid8), .speed_sat(sat8),
    .position(pos8), .dir(dir8), .err(err8)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  m_s1, m_s2, m_prev;
  bit          m_err, m_dir, m_valid;
  logic [31:0] m_pos;
  int          m_elapsed, m_len;
  int          m_acc16, m_acc8, m_speed16, m_speed8;
  bit          m_sat16, m_sat8, m_ssat16, m_ssat8;

  // Position of an AB pattern along the forward Gray cycle.
  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int clamp_w(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic model_reset();
    m_s1 = 2'b00; m_s2 = 2'b00; m_prev = 2'b00;
    m_err = 1'b0; m_dir = 1'b0; m_valid = 1'b0; m_pos = 32'd0;
    m_elapsed = 0; m_len = 1; m_acc16 = 0; m_acc8 = 0;
    m_speed16 = 0; m_speed8 = 0; m_sat16 = 1'b0; m_sat8 = 1'b0;
    m_ssat16 = 1'b0; m_ssat8 = 1'b0;
  endtask

  // One rising clock edge of the model, using the inputs currently applied.
  task automatic model_tick();
    int d, step, nxt;
    bit illegal;
    d = (gidx(m_s2) - gidx(m_prev) + 4) % 4;
    illegal = (d == 2);
    step = 0;
    if (mode_x4) begin
      if (d == 1) step = 1;
      else if (d == 3) step = -1;
    end else begin
      if (d == 1 && gidx(m_prev) == 0) step = 1;
      else if (d == 3 && gidx(m_prev) == 3) step = -1;
    end
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1   = {enc_a, enc_b};
    if (illegal) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_valid = 1'b0;
    if (en) begin
      if (step != 0) begin
        m_pos = m_pos + 32'(step);
        m_dir = (step > 0);
      end
      if (m_elapsed == 0) m_len = (win_len == 16'd0) ? 1 : int'(win_len);
      nxt = m_acc16 + step;
      m_acc16 = clamp_w(nxt, 16);
      if (m_acc16 != nxt) m_sat16 = 1'b1;
      nxt = m_acc8 + step;
      m_acc8 = clamp_w(nxt, 8);
      if (m_acc8 != nxt) m_sat8 = 1'b1;
      m_elapsed++;
      if (m_elapsed == m_len) begin
        m_speed16 = m_acc16; m_ssat16 = m_sat16;
        m_speed8  = m_acc8;  m_ssat8  = m_sat8;
        m_valid = 1'b1;
        m_acc16 = 0; m_acc8 = 0; m_sat16 = 1'b0; m_sat8 = 1'b0;
        m_elapsed = 0;
      end
    end else begin
      m_elapsed = 0; m_acc16 = 0; m_acc8 = 0; m_sat16 = 1'b0; m_sat8 = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("speed", speed, m_speed16);
    chk("speed_valid", speed_valid, m_valid);
    chk("speed_sat", speed_sat, m_ssat16);
    chk("position", position, m_pos);
    chk("dir", dir, m_dir);
    chk("err", err, m_err);
    chk("speed8", speed8, m_speed8);
    chk("speed_valid8", valid8, m_valid);
    chk("speed_sat8", sat8, m_ssat8);
  endtask

  // Advance one clock: model edge, DUT edge, compare on the falling edge.
  task automatic cycle();
    if (!rst_n) model_reset();
    else model_tick();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  // ---------------- pin stimulus ----------------
  int g;

  task automatic set_pins(input int gi);
    case (gi)
      0:       {enc_a, enc_b} = 2'b00;
      1:       {enc_a, enc_b} = 2'b10;
      2:       {enc_a, enc_b} = 2'b11;
      default: {enc_a, enc_b} = 2'b01;
    endcase
  endtask

  task automatic step_pins(input int dn);
    g = (g + dn + 4) % 4;
    set_pins(g);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit do_rst;
    bit x4;
    int dn;
    int ntrans;
    int win;
    int exp_speed;
    int exp_speed8;
    bit exp_sat8;
    int exp_pos;
    bit exp_dir;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    int got;
    logic [31:0] ep;
    if (v.do_rst) begin
      rst_n = 1'b0;
      model_reset();
      cycle();
      rst_n = 1'b1;
    end
    en = 1'b0;
    mode_x4 = v.x4;
    win_len = 16'(v.win);
    repeat (3) cycle();
    en = 1'b1;
    for (int t = 0; t < v.ntrans; t++) begin
      step_pins(v.dn);
      repeat (4) cycle();
    end
    got = 0;
    for (int k = 0; k < 1500 && got == 0; k++) begin
      if (speed_valid) got = 1;
      else cycle();
    end
    ep = v.exp_pos;
    chk($sformatf("vec%0d_valid_seen", idx), got, 1);
    chk($sformatf("vec%0d_speed", idx), speed, v.exp_speed);
    chk($sformatf("vec%0d_speed8", idx), speed8, v.exp_speed8);
    chk($sformatf("vec%0d_sat8", idx), sat8, v.exp_sat8);
    chk($sformatf("vec%0d_position", idx), position, ep);
    chk($sformatf("vec%0d_dir", idx), dir, v.exp_dir);
    en = 1'b0;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    //            rst  x4 dn  n    win   spd  spd8 sat8 pos  dir
    vecs[0] = '{1'b0, 1'b1,  1,  40,  200,  40,  40, 1'b0,  40, 1'b1};
    vecs[1] = '{1'b1, 1'b0,  1,  40,  200,  10,  10, 1'b0,  10, 1'b1};
    vecs[2] = '{1'b0, 1'b0, -1,  40,  200, -10, -10, 1'b0,   0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, -1,  12,  200, -12, -12, 1'b0, -12, 1'b0};
    vecs[4] = '{1'b0, 1'b1,  1, 200, 1000, 200, 127, 1'b1, 188, 1'b1};
    vecs[5] = '{1'b0, 1'b1,  1,   5, 1000,   5,   5, 1'b0, 193, 1'b1};

    // Reset state, with pins parked at 11 so the first sample is illegal.
    rst_n = 1'b0; en = 1'b0; mode_x4 = 1'b1; win_len = 16'd100; err_clr = 1'b0;
    g = 2; set_pins(g);
    model_reset();
    #1;
    chk("rst_speed", speed, 0);
    chk("rst_valid", speed_valid, 0);
    chk("rst_sat", speed_sat, 0);
    chk("rst_position", position, 0);
    chk("rst_dir", dir, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    chk("first_sample_err", err, 1);
    chk("first_sample_pos", position, 0);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("err_clr", err, 0);
    // 11 -> 00 illegal landing on the same edge as err_clr.
    g = 0; set_pins(g);
    cycle(); cycle();
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("err_clr_vs_illegal", err, 1);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("err_clr_again", err, 0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // win_len=0 behaves as one-cycle windows; a step every cycle gives speed +1.
    en = 1'b0; win_len = 16'd0; mode_x4 = 1'b1;
    repeat (3) cycle();
    en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step_pins(1);
      cycle();
      if (k >= 3) begin
        chk("win0_valid", speed_valid, 1);
        chk("win0_speed", speed, 1);
      end
    end
    en = 1'b0; cycle();

    // Step arriving exactly on the terminal cycle of a 10-cycle window.
    win_len = 16'd10;
    repeat (3) cycle();
    en = 1'b1;
    repeat (7) cycle();
    step_pins(1);
    repeat (3) cycle();
    chk("term_valid", speed_valid, 1);
    chk("term_speed", speed, 1);
    repeat (10) cycle();
    chk("term_next_valid", speed_valid, 1);
    chk("term_next_speed", speed, 0);
    en = 1'b0; cycle();

    // Disable mid-window while the pins keep moving.
    win_len = 16'd50; en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step_pins(1);
      repeat (2) cycle();
    end
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step_pins(($urandom_range(0, 1) == 1) ? 1 : -1);
      cycle();
      chk("dis_valid", speed_valid, 0);
      cycle();
      chk("dis_valid", speed_valid, 0);
    end
    en = 1'b1;
    repeat (15) cycle();

    // Asynchronous reset mid-window, checked before any clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_speed", speed, 0);
    chk("async_valid", speed_valid, 0);
    chk("async_sat", speed_sat, 0);
    chk("async_position", position, 0);
    chk("async_dir", dir, 0);
    chk("async_err", err, 0);
    model_reset();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;

    // Randomized phase.
    en = 1'b1; win_len = 16'd20;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) en = !en;
      if ($urandom_range(0, 49) == 0) mode_x4 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0)
        win_len = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(100, 400)) : 16'($urandom_range(0, 12));
      err_clr = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 19);
      if (r < 10) step_pins(1);
      else if (r < 12) step_pins(-1);
      else if (r == 12) step_pins(2);
      cycle();
    end
    err_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
